// File: rtl/uart_text_pkg.sv
// Shared constants and the state encoding for the UART text buffer.
// This file holds the control characters the terminal understands, the
// printable range, and the controller state type.
package uart_text_pkg;

    localparam logic [7:0] CHAR_SPACE     = 8'h20;
    localparam logic [7:0] CHAR_CR        = 8'h0D;
    localparam logic [7:0] CHAR_LF        = 8'h0A;
    localparam logic [7:0] CHAR_BS        = 8'h08;
    localparam logic [7:0] CHAR_FF        = 8'h0C;
    localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
    localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_CLEAR  = 2'd2;
    localparam logic [1:0] ST_SCROLL = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        APPLY  = ST_APPLY,
        CLEAR  = ST_CLEAR,
        SCROLL = ST_SCROLL
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CHAR_PRINT_MIN) && (c <= CHAR_PRINT_MAX);
    endfunction

endpackage

// File: rtl/screen_text_ram.sv
// Character storage for the text screen. One write port fed by the
// controller, one combinational read port the controller uses to copy rows
// during a scroll, and one registered read port owned by the renderer.
// A renderer read of an address being written in the same cycle returns
// the old contents.
module screen_text_ram
    import uart_text_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] int_addr,
    output logic [7:0]        int_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Character array update; contents are not reset because the
    // controller sweeps the whole screen with spaces after every reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign int_data = mem[int_addr];

    // Renderer read register, one cycle of latency, idles as a space.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= CHAR_SPACE;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_text_buffer.sv
// Terminal-style text buffer fed by the UART receiver. Each rising edge of
// byteReady_i captures one byte; printable bytes are written at the cursor,
// and CR, LF, BS and FF move the cursor or clear the screen. Bytes that
// arrive while a sweep is running wait in a one-entry pending register.
// Optional build macro UART_TEXT_SCROLL_EN: when defined, advancing past the
// last row scrolls the screen up one row instead of wrapping to row 0.
module uart_text_buffer
    import uart_text_pkg::*;
#(
    parameter  int COLS   = 16,
    parameter  int ROWS   = 4,
    localparam int ADDR_W = $clog2(ROWS*COLS),
    localparam int COL_W  = $clog2(COLS),
    localparam int ROW_W  = $clog2(ROWS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              byteReady_i,
    input  logic [7:0]        dataIn_i,
    input  logic [ADDR_W-1:0] charAddr_i,
    output logic [7:0]        charOut_o,
    output logic [COL_W-1:0]  cursorCol_o,
    output logic [ROW_W-1:0]  cursorRow_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS*COLS - 1);
    localparam logic [ADDR_W-1:0] COPY_END  = ADDR_W'((ROWS-1)*COLS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    state_t            state;
    logic              busy;
    logic [ADDR_W-1:0] sweep_addr;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic [7:0]        cur_byte;
    logic              pending_valid;
    logic [7:0]        pending_byte;
    logic              overflow;
    logic              byte_ready_q;

    logic              byte_edge;
    logic [ADDR_W-1:0] cursor_addr;
    logic              printable;
    logic              row_advance;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] int_addr;
    logic [7:0]        int_data;
    logic              copy_en;

    assign byte_edge   = byteReady_i & ~byte_ready_q;
    assign cursor_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);
    assign printable   = is_printable(cur_byte);
    assign row_advance = (state == APPLY) &&
                         ((printable && (cursor_col == COL_LAST)) || (cur_byte == CHAR_LF));
    assign int_addr    = sweep_addr + ADDR_W'(COLS);

    // Select what, if anything, is written to the character array this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cursor_addr;
        wr_data = CHAR_SPACE;
        copy_en = 1'b0;
        case (state)
            APPLY: begin
                if (printable) begin
                    wr_en   = 1'b1;
                    wr_data = cur_byte;
                end else if ((cur_byte == CHAR_BS) && (cursor_col != '0)) begin
                    wr_en   = 1'b1;
                    wr_addr = cursor_addr - ADDR_W'(1);
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = sweep_addr;
            end
`ifdef UART_TEXT_SCROLL_EN
            SCROLL: begin
                wr_en   = 1'b1;
                wr_addr = sweep_addr;
                copy_en = (sweep_addr < COPY_END);
            end
`endif
            default: begin
            end
        endcase
        if (copy_en) begin
            wr_data = int_data;
        end
    end

    // Controller: byte capture, pending slot, cursor movement and sweeps.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= CLEAR;
            busy          <= 1'b1;
            sweep_addr    <= '0;
            cursor_col    <= '0;
            cursor_row    <= '0;
            cur_byte      <= 8'h00;
            pending_valid <= 1'b0;
            pending_byte  <= 8'h00;
            overflow      <= 1'b0;
            byte_ready_q  <= 1'b0;
        end else begin
            byte_ready_q <= byteReady_i;
            case (state)
                IDLE: begin
                    if (pending_valid) begin
                        state    <= APPLY;
                        cur_byte <= pending_byte;
                        if (byte_edge) begin
                            pending_byte <= dataIn_i;
                        end else begin
                            pending_valid <= 1'b0;
                        end
                    end else if (byte_edge) begin
                        state    <= APPLY;
                        cur_byte <= dataIn_i;
                    end
                end
                APPLY: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (printable) begin
                        cursor_col <= (cursor_col == COL_LAST) ? '0 : cursor_col + COL_W'(1);
                    end else if ((cur_byte == CHAR_CR) || (cur_byte == CHAR_LF)) begin
                        cursor_col <= '0;
                    end else if (cur_byte == CHAR_BS) begin
                        if (cursor_col != '0) begin
                            cursor_col <= cursor_col - COL_W'(1);
                        end
                    end else if (cur_byte == CHAR_FF) begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        sweep_addr <= '0;
                    end
                    if (row_advance) begin
                        if (cursor_row == ROW_LAST) begin
`ifdef UART_TEXT_SCROLL_EN
                            state      <= SCROLL;
                            busy       <= 1'b1;
                            sweep_addr <= '0;
`else
                            cursor_row <= '0;
`endif
                        end else begin
                            cursor_row <= cursor_row + ROW_W'(1);
                        end
                    end
                end
                CLEAR: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sweep_addr <= sweep_addr + ADDR_W'(1);
                    end
                end
`ifdef UART_TEXT_SCROLL_EN
                SCROLL: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sweep_addr <= sweep_addr + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (byte_edge && (state != IDLE)) begin
                if (pending_valid) begin
                    overflow <= 1'b1;
                end else begin
                    pending_valid <= 1'b1;
                    pending_byte  <= dataIn_i;
                end
            end
        end
    end

    screen_text_ram #(
        .DEPTH  (ROWS*COLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk_i),
        .reset    (reset_i),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .int_addr (int_addr),
        .int_data (int_data),
        .rd_addr  (charAddr_i),
        .rd_data  (charOut_o)
    );

    assign cursorCol_o = cursor_col;
    assign cursorRow_o = cursor_row;
    assign busy_o      = busy;
    assign overflow_o  = overflow;

endmodule

// File: doc/uart_text_buffer.md
Name: uart_text_buffer

Overview:
Stage directly downstream of the UART receiver. It consumes received bytes and maintains a ROWS x COLS character buffer for the screen renderer. The buffer is handled as a terminal: printable bytes are written at a cursor, and a small control-character set moves or clears it. A separate registered read port serves the renderer, independent of the write side.

Parameters:
COLS, 16, characters per row
ROWS, 4, number of rows
ADDR_W, $clog2(ROWS*COLS), character address width (derived; do not override)

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
byteReady_i  in  1  receiver byte-ready level; stays high until the next start bit
dataIn_i  in  8  received byte, valid while byteReady_i is high
charAddr_i  in  ADDR_W  renderer read address, row*COLS+col
charOut_o  out  8  renderer read data, 1-cycle latency
cursorCol_o  out  $clog2(COLS)  current cursor column
cursorRow_o  out  $clog2(ROWS)  current cursor row
busy_o  out  1  high during CLEAR or SCROLL sweep
overflow_o  out  1  sticky; a byte was dropped

Behaviour:
- Reset values: cursor 0,0; charOut_o=0x20; overflow_o=0; pending empty; byteReady edge register=0. State enters CLEAR, so busy_o=1 on the first cycle after reset.
- Byte capture:
  - A byte is captured on the rising edge of byteReady_i (registered previous value).
  - A level held high produces exactly one capture.
  - dataIn_i is sampled in the edge cycle.
- States: IDLE, APPLY, CLEAR, SCROLL.
- IDLE: an edge or a pending byte moves to APPLY with that byte. The pending byte has priority; a same-cycle edge goes into pending.
- APPLY (1 cycle):
  - 0x20..0x7E: write the byte at row*COLS+col, then col+1. At col==COLS-1: col=0 and row advances.
  - 0x0D: col=0.
  - 0x0A: col=0 and row advances.
  - 0x08: if col>0, col-1 and write 0x20 at the new position. At col==0 it is a no-op.
  - 0x0C: cursor 0,0, then go to CLEAR.
  - All other bytes are ignored.
  - Next state is IDLE unless CLEAR or SCROLL applies.
- Row advance:
  - row<ROWS-1: row+1.
  - row==ROWS-1: wrap to row 0 (without the optional feature; see below).
- CLEAR: writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle. Lasts exactly ROWS*COLS cycles, then IDLE.
- Edges arriving while busy: latched into the 1-entry pending register. If pending is already full, the new byte is dropped and overflow_o is set. overflow_o clears only on reset.
- Write visibility: a write in cycle N is visible on charOut_o for a matching charAddr_i presented in cycle N+1.
- Read/write collision: a renderer read of an address written in the same cycle returns the old value.
- Reset mid-sweep: aborts the sweep, restarts CLEAR from address 0 and discards pending.

Optional Feature:
UART_TEXT_SCROLL_EN
- Defined:
  - A row advance at row==ROWS-1 keeps row at ROWS-1 and enters SCROLL.
  - SCROLL copies address a+COLS into a for a=0..(ROWS-1)*COLS-1, one per cycle.
  - It then writes 0x20 to the last row, one per cycle.
  - Total ROWS*COLS cycles, busy_o=1 throughout.
- Undefined: row wraps to 0, no SCROLL state, and existing row contents are overwritten in place.

Decomposition:
- Package uart_text_pkg holds:
  - character constants CHAR_SPACE, CHAR_CR, CHAR_LF, CHAR_BS, CHAR_FF, CHAR_PRINT_MIN, CHAR_PRINT_MAX
  - state encoding localparams
- Sub-module screen_text_ram, a register-array memory with:
  - one write port
  - one combinational internal read port (scroll copy)
  - one registered renderer read port

Test Plan:
- Reset, then wait -> busy_o high for exactly 64 cycles; afterwards every address reads 0x20 and the cursor is 0,0.
- Send 0x41 with byteReady held high for 500 cycles -> address 0 = 0x41; address 1 stays 0x20; cursorCol_o=1.
- Send 16 x 0x42 -> addresses 0..15 = 0x42; cursor row 1, col 0.
- Send 0x41, 0x08, then 0x08 again -> address 0 = 0x20 and col=0; the second BS is a no-op.
- Cursor at row 3, send 0x0A:
  - Without macro -> row 0, contents intact.
  - With macro -> busy_o for 64 cycles, row r holds the old row r+1, row 3 is all 0x20, cursor 3,0.
- Send 0x0C, then two edges during CLEAR -> first edge is applied after CLEAR; second is dropped and overflow_o=1.
